memif_arb_n: RTL and testbench
==============================

// Module: memif_arb_n
// PURPOSE
//  N-port arbiter for the memif burst interface (addr/len/rw/valid/ready + wdata/wack/wlast + rdata/rstb/rlast).
//  Generalises the fixed 2-port memif arbiter: parametric port count, round-robin or fixed priority, per-port write disable.
//  Sits between requesters (HDMI reader, SPI writer, ...) and qpi_memctrl.
//  One transaction is outstanding at a time; the grant is held from command issue until the last data beat.
// PARAMETERS
//  N              4        number of downstream requester ports (2..8)
//  AW             32       address width
//  DW             16       data width
//  LW             7        burst length field width, passed through unmodified
//  RR             1        1 = round-robin, 0 = fixed priority (port 0 highest)
//  WRITE_DISABLE  {N{1'b0}} bit i set: port i is read-only; its rw is forced to 1 (read)
// PORTS
//  clk       in   1      system clock (clk_1x domain)
//  rst       in   1      synchronous reset, active-high
//  d_addr    in   N*AW   per-port command address, port i at [i*AW+:AW]
//  d_len     in   N*LW   per-port burst length
//  d_rw      in   N      per-port direction; 1 = read, 0 = write
//  d_valid   in   N      per-port command request
//  d_ready   out  N      per-port command accept (one-cycle pulse)
//  d_wdata   in   N*DW   per-port write data
//  d_wack    out  N      per-port write-data consumed strobe
//  d_wlast   out  N      per-port last write beat
//  d_rdata   out  N*DW   read data, u_rdata broadcast to every slice
//  d_rstb    out  N      per-port read-data strobe
//  d_rlast   out  N      per-port last read beat
//  u_addr    out  AW     command address to controller
//  u_len     out  LW     burst length to controller
//  u_rw      out  1      direction to controller
//  u_valid   out  1      command valid to controller
//  u_ready   in   1      controller accepts command
//  u_wdata   out  DW     write data from the granted port
//  u_wack    in   1      controller consumed write word
//  u_wlast   in   1      qualifies u_wack as the final write beat
//  u_rdata   in   DW     read data from controller
//  u_rstb    in   1      read data strobe
//  u_rlast   in   1      qualifies u_rstb as the final read beat
// BEHAVIOUR
//  Reset: state IDLE, gnt=0, rr pointer=0. u_valid=0, u_addr/u_len=0, u_rw=1.
//   d_ready, d_wack, d_wlast, d_rstb and d_rlast are all 0.
//  FSM IDLE -> CMD -> DATA -> IDLE:
//   IDLE: if any d_valid, the picker selects winner w. Register gnt=onehot(w), then latch
//    addr, len and rw_eff = d_rw[w] | WRITE_DISABLE[w]. Go to CMD.
//    u_valid rises the cycle after d_valid is first seen (1-cycle latency).
//   CMD: u_valid=1 holds the latched fields stable. On u_valid&u_ready, pulse d_ready[w]
//    combinationally in the same cycle, drop u_valid next cycle, go to DATA.
//   DATA: u_wdata = d_wdata[w] (combinational mux). d_wack[w]=u_wack, d_wlast[w]=u_wlast,
//    d_rstb[w]=u_rstb, d_rlast[w]=u_rlast, all gated by gnt. Non-granted strobes stay 0.
//    Exit to IDLE on (u_wack&u_wlast) for writes or (u_rstb&u_rlast) for reads.
//    In that same cycle, update the rr pointer to w+1 mod N.
//  Round-robin: search starts at the pointer and wraps N-1 -> 0.
//   A port cannot win twice in a row while another port is requesting.
//  Fixed priority: the lowest index wins and the pointer is ignored.
//  A requester must hold d_valid and its fields until d_ready. Deasserting d_valid before
//   d_ready is not supported; once latched, the command completes regardless.
//  Strobes arriving in IDLE or CMD are ignored and not forwarded.
//  Back-to-back: the earliest new u_valid is 1 cycle after the last beat, since IDLE spends one cycle picking.
//  Reset mid-transaction returns to IDLE immediately; the controller is reset on the same rst.
// STRUCTURE
//  memif_defs.vh: MEMIF_RD=1'b1, MEMIF_WR=1'b0, FSM state encodings (2 bits).
//  Sub-module arb_pick_n (N, RR): inputs req[N] and ptr; outputs onehot gnt and index. Purely combinational.
//  Datapath muxes use onehot AND-OR; no priority-encoded mux chains.
// TESTING
//  1 N=4 RR=1, ports 0..3 each request a read, len=3 -> grants in order 0,1,2,3. Each gets 4 rstb with rlast on the 4th.
//  2 Port 2 requests again immediately after its own grant while port 0 also waits -> port 0 is granted before port 2.
//  3 RR=0, ports 1 and 3 valid together -> port 1 first. Port 3 waits through port 1's full burst.
//  4 WRITE_DISABLE=4'b0010, port 1 issues rw=0 -> u_rw=1, the burst completes as a read, and no d_wack reaches port 1.
//  5 Write len=7 on port 3, wdata=0x1000+k -> u_wdata follows port 3 and the 8th wack carries wlast.
//   Other ports see d_wack=0 throughout.
//  6 rst asserted during DATA of a read at beat 2 -> next cycle: u_valid=0, all d_* strobes 0, IDLE.
//   A new request gives u_valid 1 cycle later.

Source files
------------

// File: rtl/memif_arb_n_pkg.sv
// Shared types and constants for the N-port memif burst arbiter.
package memif_arb_n_pkg;

  localparam logic MEMIF_RD = 1'b1;
  localparam logic MEMIF_WR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Width of a port index; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memif_arb_n_pick.sv
// Combinational request picker: round-robin from ptr, or fixed priority with port 0 highest.
module memif_arb_n_pick
  import memif_arb_n_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter bit          RR = 1'b1,
  localparam int unsigned PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [PW-1:0] cand;
  logic          found;

  // Walk the candidates in priority order; the first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = RR ? PW'((32'(ptr) + k) % N) : PW'(k);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/memif_arb_n.sv
// N-port memif burst arbiter; one transaction outstanding, grant held from command to last beat.
module memif_arb_n
  import memif_arb_n_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 16,
  parameter int unsigned LW            = 7,
  parameter bit          RR            = 1'b1,
  parameter logic [N-1:0] WRITE_DISABLE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*AW-1:0] d_addr,
  input  logic [N*LW-1:0] d_len,
  input  logic [N-1:0]    d_rw,
  input  logic [N-1:0]    d_valid,
  output logic [N-1:0]    d_ready,
  input  logic [N*DW-1:0] d_wdata,
  output logic [N-1:0]    d_wack,
  output logic [N-1:0]    d_wlast,
  output logic [N*DW-1:0] d_rdata,
  output logic [N-1:0]    d_rstb,
  output logic [N-1:0]    d_rlast,
  output logic [AW-1:0]   u_addr,
  output logic [LW-1:0]   u_len,
  output logic            u_rw,
  output logic            u_valid,
  input  logic            u_ready,
  output logic [DW-1:0]   u_wdata,
  input  logic            u_wack,
  input  logic            u_wlast,
  input  logic [DW-1:0]   u_rdata,
  input  logic            u_rstb,
  input  logic            u_rlast
);

  localparam int unsigned PW = ptr_width(N);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic          rw_q, rw_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] pick_idx;
  logic [AW-1:0] pick_addr;
  logic [LW-1:0] pick_len;
  logic          pick_rw;
  logic [DW-1:0] wdata_mux;
  logic          cmd_fire;
  logic          last_beat;
  logic          in_data;
  logic          is_wr;

  memif_arb_n_pick #(
    .N  (N),
    .RR (RR)
  ) u_pick (
    .req (d_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Onehot AND-OR selection of the winner's command and the granted port's write data.
  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    pick_rw   = 1'b0;
    wdata_mux = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pick_addr = pick_addr | (d_addr[i*AW +: AW] & {AW{pick_gnt[i]}});
      pick_len  = pick_len  | (d_len[i*LW +: LW]  & {LW{pick_gnt[i]}});
      pick_rw   = pick_rw   | (pick_gnt[i] & (d_rw[i] | WRITE_DISABLE[i]));
      wdata_mux = wdata_mux | (d_wdata[i*DW +: DW] & {DW{gnt_q[i]}});
    end
  end

  // Next-state logic for the IDLE -> CMD -> DATA transaction sequence.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rw_d      = rw_q;
    valid_d   = valid_q;
    cmd_fire  = 1'b0;
    last_beat = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|d_valid) begin
          state_d = ST_CMD;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          addr_d  = pick_addr;
          len_d   = pick_len;
          rw_d    = pick_rw;
          valid_d = 1'b1;
        end
      end
      ST_CMD: begin
        if (u_ready) begin
          cmd_fire = 1'b1;
          valid_d  = 1'b0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        last_beat = (rw_q == MEMIF_RD) ? (u_rstb & u_rlast) : (u_wack & u_wlast);
        if (last_beat) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      rw_q    <= MEMIF_RD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
    end
  end

  // Strobes only reach the granted port during DATA, and only in the latched direction.
  assign in_data = (state_q == ST_DATA);
  assign is_wr   = (rw_q == MEMIF_WR);

  assign d_ready = gnt_q & {N{cmd_fire}};
  assign d_wack  = gnt_q & {N{in_data & is_wr & u_wack}};
  assign d_wlast = gnt_q & {N{in_data & is_wr & u_wlast}};
  assign d_rstb  = gnt_q & {N{in_data & ~is_wr & u_rstb}};
  assign d_rlast = gnt_q & {N{in_data & ~is_wr & u_rlast}};
  assign d_rdata = {N{u_rdata}};

  assign u_addr  = addr_q;
  assign u_len   = len_q;
  assign u_rw    = rw_q;
  assign u_valid = valid_q;
  assign u_wdata = wdata_mux;

endmodule

// File: tb/tb_memif_arb_n.sv
// Bench for memif_arb_n: table of arbitration scenarios plus hand-written corner sequences.
module tb_memif_arb_n;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 7;
  localparam logic [N-1:0] WD_RR = 4'b0010;

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          rw;
    logic [DW-1:0] wbase;
  } exp_t;

  typedef struct packed {
    logic            fp;
    logic [N-1:0]    req;
    logic [N-1:0]    rw;
    logic [LW-1:0]   len;
    logic [2:0]      cnt;
    logic [3:0][1:0] ord;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] d_addr;
  logic [N*LW-1:0] d_len;
  logic [N-1:0]    d_rw, d_valid;
  logic [N*DW-1:0] d_wdata;
  logic            u_ready, u_wack, u_wlast, u_rstb, u_rlast;
  logic [DW-1:0]   u_rdata;
  logic            use_fp;
  logic [N-1:0]    wd_mask;

  logic [N-1:0]    rr_d_ready, rr_d_wack, rr_d_wlast, rr_d_rstb, rr_d_rlast;
  logic [N*DW-1:0] rr_d_rdata;
  logic [AW-1:0]   rr_u_addr;
  logic [LW-1:0]   rr_u_len;
  logic            rr_u_rw, rr_u_valid;
  logic [DW-1:0]   rr_u_wdata;
  logic [N-1:0]    fp_d_ready, fp_d_wack, fp_d_wlast, fp_d_rstb, fp_d_rlast;
  logic [N*DW-1:0] fp_d_rdata;
  logic [AW-1:0]   fp_u_addr;
  logic [LW-1:0]   fp_u_len;
  logic            fp_u_rw, fp_u_valid;
  logic [DW-1:0]   fp_u_wdata;

  logic [N-1:0]    o_d_ready, o_d_wack, o_d_wlast, o_d_rstb, o_d_rlast;
  logic [N*DW-1:0] o_d_rdata;
  logic [AW-1:0]   o_u_addr;
  logic [LW-1:0]   o_u_len;
  logic            o_u_rw, o_u_valid;
  logic [DW-1:0]   o_u_wdata;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  memif_arb_n #(.N(N), .AW(AW), .DW(DW), .LW(LW), .RR(1'b1), .WRITE_DISABLE(WD_RR)) u_dut_rr (
    .clk(clk), .rst(rst), .d_addr(d_addr), .d_len(d_len), .d_rw(d_rw), .d_valid(d_valid),
    .d_ready(rr_d_ready), .d_wdata(d_wdata), .d_wack(rr_d_wack), .d_wlast(rr_d_wlast),
    .d_rdata(rr_d_rdata), .d_rstb(rr_d_rstb), .d_rlast(rr_d_rlast), .u_addr(rr_u_addr),
    .u_len(rr_u_len), .u_rw(rr_u_rw), .u_valid(rr_u_valid), .u_ready(u_ready),
    .u_wdata(rr_u_wdata), .u_wack(u_wack), .u_wlast(u_wlast), .u_rdata(u_rdata),
    .u_rstb(u_rstb), .u_rlast(u_rlast)
  );

  memif_arb_n #(.N(N), .AW(AW), .DW(DW), .LW(LW), .RR(1'b0), .WRITE_DISABLE(4'b0000)) u_dut_fp (
    .clk(clk), .rst(rst), .d_addr(d_addr), .d_len(d_len), .d_rw(d_rw), .d_valid(d_valid),
    .d_ready(fp_d_ready), .d_wdata(d_wdata), .d_wack(fp_d_wack), .d_wlast(fp_d_wlast),
    .d_rdata(fp_d_rdata), .d_rstb(fp_d_rstb), .d_rlast(fp_d_rlast), .u_addr(fp_u_addr),
    .u_len(fp_u_len), .u_rw(fp_u_rw), .u_valid(fp_u_valid), .u_ready(u_ready),
    .u_wdata(fp_u_wdata), .u_wack(u_wack), .u_wlast(u_wlast), .u_rdata(u_rdata),
    .u_rstb(u_rstb), .u_rlast(u_rlast)
  );

  // Both instances share stimulus; use_fp picks which one is being observed.
  assign o_d_ready = use_fp ? fp_d_ready : rr_d_ready;
  assign o_d_wack  = use_fp ? fp_d_wack  : rr_d_wack;
  assign o_d_wlast = use_fp ? fp_d_wlast : rr_d_wlast;
  assign o_d_rstb  = use_fp ? fp_d_rstb  : rr_d_rstb;
  assign o_d_rlast = use_fp ? fp_d_rlast : rr_d_rlast;
  assign o_d_rdata = use_fp ? fp_d_rdata : rr_d_rdata;
  assign o_u_addr  = use_fp ? fp_u_addr  : rr_u_addr;
  assign o_u_len   = use_fp ? fp_u_len   : rr_u_len;
  assign o_u_rw    = use_fp ? fp_u_rw    : rr_u_rw;
  assign o_u_valid = use_fp ? fp_u_valid : rr_u_valid;
  assign o_u_wdata = use_fp ? fp_u_wdata : rr_u_wdata;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int p);
    return N'(1) << p;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int r, input int p);
    return 32'h4000_0000 + 32'(r * 256) + 32'(p * 16);
  endfunction

  function automatic vec_t mk(input logic fp, input logic [N-1:0] req, input logic [N-1:0] rw,
                              input int len, input int cnt, input int o0, input int o1,
                              input int o2, input int o3);
    vec_t v;
    v.fp = fp; v.req = req; v.rw = rw; v.len = LW'(len); v.cnt = 3'(cnt);
    v.ord[0] = 2'(o0); v.ord[1] = 2'(o1); v.ord[2] = 2'(o2); v.ord[3] = 2'(o3);
    return v;
  endfunction

  function automatic exp_t mk_exp(input int r, input int p, input logic [LW-1:0] len,
                                  input logic rw, input logic fp);
    exp_t e;
    e.port  = p;
    e.addr  = addr_of(r, p);
    e.len   = len;
    e.rw    = rw | (fp ? 1'b0 : wd_mask[p]);
    e.wbase = 16'h1000;
    return e;
  endfunction

  task automatic setup_ports(input int r, input logic [LW-1:0] len, input logic [N-1:0] rw);
    for (int i = 0; i < N; i++) begin
      d_addr[i*AW +: AW]  = addr_of(r, i);
      d_len[i*LW +: LW]   = len;
      d_wdata[i*DW +: DW] = 16'hA000 + 16'(i);
    end
    d_rw = rw;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    d_valid = '0; u_ready = 1'b0; u_wack = 1'b0; u_wlast = 1'b0;
    u_rstb = 1'b0; u_rlast = 1'b0; u_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_u_valid", 64'(o_u_valid), 64'd0);
    chk("rst_u_addr_len", {o_u_addr, 25'(o_u_len)}, 64'd0);
    chk("rst_u_rw", 64'(o_u_rw), 64'd1);
    chk("rst_strobes", {o_d_ready, o_d_wack, o_d_wlast, o_d_rstb, o_d_rlast}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (o_u_valid !== 1'b1 && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("u_valid_wait", 64'(o_u_valid), 64'd1);
  endtask

  task automatic handshake(input exp_t e, input bit keep);
    wait_valid();
    chk("u_addr", 64'(o_u_addr), 64'(e.addr));
    chk("u_len", 64'(o_u_len), 64'(e.len));
    chk("u_rw", 64'(o_u_rw), 64'(e.rw));
    u_rstb = 1'b1; u_rlast = 1'b1; u_wack = 1'b1; u_wlast = 1'b1;
    #1;
    chk("strobe_in_cmd", {o_d_rstb, o_d_rlast, o_d_wack, o_d_wlast}, 64'd0);
    chk("ready_before_accept", 64'(o_d_ready), 64'd0);
    u_rstb = 1'b0; u_rlast = 1'b0; u_wack = 1'b0; u_wlast = 1'b0;
    u_ready = 1'b1;
    #1;
    chk("d_ready", 64'(o_d_ready), 64'(oh(e.port)));
    @(posedge clk);
    #1;
    u_ready = 1'b0;
    if (!keep) d_valid[e.port] = 1'b0;
    chk("u_valid_drop", 64'(o_u_valid), 64'd0);
  endtask

  task automatic beats(input exp_t e, input int n);
    for (int k = 0; k < n; k++) begin
      bit last;
      last = (k == int'(e.len));
      if (e.rw) begin
        u_rdata = 16'h5A00 + 16'(k); u_rstb = 1'b1; u_rlast = last;
      end else begin
        d_wdata[e.port*DW +: DW] = e.wbase + 16'(k); u_wack = 1'b1; u_wlast = last;
      end
      #1;
      if (e.rw) begin
        chk("d_rstb", 64'(o_d_rstb), 64'(oh(e.port)));
        chk("d_rlast", 64'(o_d_rlast), last ? 64'(oh(e.port)) : 64'd0);
        chk("d_rdata", o_d_rdata, {N{u_rdata}});
        chk("d_wack_on_read", 64'(o_d_wack), 64'd0);
      end else begin
        chk("u_wdata", 64'(o_u_wdata), 64'(e.wbase + 16'(k)));
        chk("d_wack", 64'(o_d_wack), 64'(oh(e.port)));
        chk("d_wlast", 64'(o_d_wlast), last ? 64'(oh(e.port)) : 64'd0);
        chk("d_rstb_on_write", 64'(o_d_rstb), 64'd0);
      end
      chk("u_valid_in_data", 64'(o_u_valid), 64'd0);
      @(posedge clk);
      #1;
      u_rstb = 1'b0; u_rlast = 1'b0; u_wack = 1'b0; u_wlast = 1'b0;
      if (!last && $urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic serve(input exp_t e, input bit keep);
    handshake(e, keep);
    beats(e, int'(e.len) + 1);
    chk("idle_after_last", 64'(o_u_valid), 64'd0);
    d_wdata[e.port*DW +: DW] = 16'hA000 + 16'(e.port);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    exp_t e;
    use_fp = 1'b0;
    wd_mask = WD_RR;
    d_addr = '0; d_len = '0; d_rw = '0; d_wdata = '0;

    tbl[0] = mk(1'b0, 4'b1111, 4'b1111, 3, 4, 0, 1, 2, 3);
    tbl[1] = mk(1'b1, 4'b1010, 4'b1111, 3, 2, 1, 3, 0, 0);
    tbl[2] = mk(1'b0, 4'b0010, 4'b0000, 2, 1, 1, 0, 0, 0);
    tbl[3] = mk(1'b0, 4'b1000, 4'b0000, 7, 1, 3, 0, 0, 0);
    tbl[4] = mk(1'b1, 4'b1111, 4'b0101, 1, 4, 0, 1, 2, 3);
    tbl[5] = mk(1'b0, 4'b1111, 4'b0000, 0, 4, 0, 1, 2, 3);
    tbl[6] = mk(1'b0, 4'b1001, 4'b1111, 0, 2, 0, 3, 0, 0);

    for (int r = 0; r < 7; r++) begin
      vec_t v;
      v = tbl[r];
      use_fp = v.fp;
      do_reset();
      setup_ports(r, v.len, v.rw);
      d_valid = v.req;
      for (int k = 0; k < int'(v.cnt); k++)
        sb.push_back(mk_exp(r, int'(v.ord[k]), v.len, v.rw[v.ord[k]], v.fp));
      while (sb.size() > 0) begin
        e = sb.pop_front();
        serve(e, 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("no_stray_grant", 64'(o_u_valid), 64'd0);
    end

    // Strobes seen while idle must not leak to any port.
    use_fp = 1'b0;
    do_reset();
    u_rstb = 1'b1; u_rlast = 1'b1; u_wack = 1'b1; u_wlast = 1'b1;
    #1;
    chk("strobe_in_idle", {o_d_rstb, o_d_rlast, o_d_wack, o_d_wlast}, 64'd0);
    @(posedge clk);
    #1;
    u_rstb = 1'b0; u_rlast = 1'b0; u_wack = 1'b0; u_wlast = 1'b0;
    chk("idle_stays_idle", 64'(o_u_valid), 64'd0);

    // Port 2 re-requests at once while port 0 waits; port 0 must go first.
    setup_ports(8, 7'd1, 4'b1111);
    d_valid = 4'b0010;
    sb.push_back(mk_exp(8, 1, 7'd1, 1'b1, 1'b0));
    e = sb.pop_front();
    serve(e, 1'b0);
    d_valid = 4'b0101;
    sb.push_back(mk_exp(8, 2, 7'd1, 1'b1, 1'b0));
    e = sb.pop_front();
    serve(e, 1'b1);
    sb.push_back(mk_exp(8, 0, 7'd1, 1'b1, 1'b0));
    sb.push_back(mk_exp(8, 2, 7'd1, 1'b1, 1'b0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      serve(e, 1'b0);
    end

    // Reset in the middle of a read burst, then verify one-cycle command latency.
    do_reset();
    setup_ports(9, 7'd3, 4'b1111);
    d_valid = 4'b0001;
    e = mk_exp(9, 0, 7'd3, 1'b1, 1'b0);
    handshake(e, 1'b0);
    beats(e, 2);
    u_rdata = 16'h5A02; u_rstb = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_u_valid", 64'(o_u_valid), 64'd0);
    chk("mid_rst_strobes", {o_d_ready, o_d_wack, o_d_wlast, o_d_rstb, o_d_rlast}, 64'd0);
    rst = 1'b0;
    u_rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(o_u_valid), 64'd0);
    d_valid = 4'b0010;
    #1;
    chk("valid_not_same_cycle", 64'(o_u_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("valid_latency", 64'(o_u_valid), 64'd1);
    e = mk_exp(9, 1, 7'd3, 1'b1, 1'b0);
    serve(e, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
